wb_unit: RTL and testbench

Writeback stage of the riscv_core pipeline. Registers the memory-stage result, extracts and extends load data from the synchronous data memory, selects the final writeback value, and drives the register file's write port (we/wa/wd) together with its same-cycle forwarding controls (regWrForward1/2). Enforces exactly-once writeback per instruction under stall and holds load data stable across stalls.

---
 rtl/riscv_core_pkg.sv | 12 +
 rtl/load_align.sv | 30 +++
 rtl/wb_unit.sv | 92 +++++++++
 tb/tb_wb_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_pkg.sv
// Shared riscv_core encodings: writeback source selects and load funct3 codes.
package riscv_core_pkg;
  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
endpackage

// File: rtl/load_align.sv
// Load data extraction: picks byte/halfword/word from a memory word and extends it.
// Latency: purely combinational.
// Backpressure: none, no state.
module load_align
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    // Halfword position comes from offset[1] only; a misaligned bit 0 is ignored.
    half_sel = offset[1] ? word[16 +: 16] : word[0 +: 16];
    value    = word;
    case (funct3)
      F3_LB:   value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   value = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  value = {{(XLEN-16){1'b0}}, half_sel};
      default: value = word;
    endcase
  end
endmodule

// File: rtl/wb_unit.sv
// Writeback stage: registers the memory-stage result and drives the register file write port.
// Latency: instruction accepted at edge N writes the register file at edge N+1.
// Backpressure: stall holds the slot; the write fires once and load data is held stable.
module wb_unit
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic            mem_reg_we,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [1:0]      mem_wb_sel,
  input  logic [2:0]      mem_load_f3,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_pc_plus4,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic [RA_W-1:0] dec_ra1,
  input  logic [RA_W-1:0] dec_ra2,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            rf_fwd1,
  output logic            rf_fwd2,
  output logic            wb_valid
);
  logic            valid;
  logic            reg_we;
  logic [RA_W-1:0] rd;
  logic [1:0]      wb_sel;
  logic [2:0]      load_f3;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] pc_plus4;
  logic            done;
  logic [XLEN-1:0] held;
  logic [XLEN-1:0] aligned;
  logic [XLEN-1:0] load_val;

  load_align #(.XLEN(XLEN)) u_align (
    .word   (dmem_rdata),
    .offset (alu_result[1:0]),
    .funct3 (load_f3),
    .value  (aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 1'b0;
      reg_we     <= 1'b0;
      rd         <= '0;
      wb_sel     <= WB_SEL_ALU;
      load_f3    <= F3_LB;
      alu_result <= '0;
      pc_plus4   <= '0;
      done       <= 1'b0;
      held       <= '0;
    end else if (stall) begin
      // The memory word is only valid in the first WB cycle, so capture it then.
      if (!done) begin
        held <= aligned;
        done <= 1'b1;
      end
    end else begin
      valid      <= mem_valid & ~flush;
      reg_we     <= mem_reg_we;
      rd         <= mem_rd;
      wb_sel     <= mem_wb_sel;
      load_f3    <= mem_load_f3;
      alu_result <= mem_alu_result;
      pc_plus4   <= mem_pc_plus4;
      done       <= 1'b0;
    end
  end

  always_comb begin
    load_val = done ? held : aligned;
    rf_we    = valid & reg_we & (rd != '0) & ~done;
    rf_wa    = rd;
    case (wb_sel)
      WB_SEL_LOAD: rf_wd = load_val;
      WB_SEL_PC4:  rf_wd = pc_plus4;
      default:     rf_wd = alu_result;
    endcase
    rf_fwd1  = rf_we & (rf_wa == dec_ra1);
    rf_fwd2  = rf_we & (rf_wa == dec_ra2);
    wb_valid = valid;
  end
endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed scenarios plus a randomized run against a reference model.
module tb_wb_unit;
  logic        clk = 1'b0;
  logic        rst, stall, flush, mem_valid, mem_reg_we;
  logic [4:0]  mem_rd, dec_ra1, dec_ra2, rf_wa;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_load_f3;
  logic [31:0] mem_alu_result, mem_pc_plus4, dmem_rdata, rf_wd;
  logic        rf_we, rf_fwd1, rf_fwd2, wb_valid;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  wb_unit #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_we(mem_reg_we), .mem_rd(mem_rd),
    .mem_wb_sel(mem_wb_sel), .mem_load_f3(mem_load_f3),
    .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
    .dmem_rdata(dmem_rdata), .dec_ra1(dec_ra1), .dec_ra2(dec_ra2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .rf_fwd1(rf_fwd1), .rf_fwd2(rf_fwd2), .wb_valid(wb_valid)
  );

  // Load result from the architectural rules, using shifts and masks on the word.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc);
    mem_valid = v; mem_reg_we = we; mem_rd = rd; mem_wb_sel = sel;
    mem_load_f3 = f3; mem_alu_result = alu; mem_pc_plus4 = pc;
  endtask

  task automatic test_reset;
    stall = 1'b0; flush = 1'b0; dmem_rdata = 32'h0; dec_ra1 = 5'd0; dec_ra2 = 5'd0;
    drive(1'b1, 1'b1, 5'd7, 2'd0, 3'd2, 32'hDEAD_BEEF, 32'h44);
    rst = 1'b1;
    tick;
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd, rf_fwd1, rf_fwd2, wb_valid} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: we=%b wa=%0d wd=%h fwd=%b%b valid=%b, required all 0",
               rf_we, rf_wa, rf_wd, rf_fwd1, rf_fwd2, wb_valid);
    end
    // Reset while a stalled write is pending must drop it.
    rst = 1'b0;
    tick;
    stall = 1'b1; rst = 1'b1;
    tick;
    n_cmp++;
    if ({rf_we, wb_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_stall: we=%b valid=%b, required 0 0", rf_we, wb_valid);
    end
    rst = 1'b0; stall = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0);
    tick;
  endtask

  task automatic test_alu;
    drive(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'h1234, 32'h100);
    tick;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0);
    dec_ra1 = 5'd5; dec_ra2 = 5'd6;
    #1;
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd5, 32'h1234}) begin
      n_fail++;
      $display("FAIL alu_write: we=%b wa=%0d wd=%h, required 1 5 00001234", rf_we, rf_wa, rf_wd);
    end
    n_cmp++;
    if ({rf_fwd1, rf_fwd2} !== 2'b10) begin
      n_fail++;
      $display("FAIL alu_fwd: fwd1=%b fwd2=%b, required 1 0", rf_fwd1, rf_fwd2);
    end
    tick;
    n_cmp++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_once: we=%b, required 0", rf_we);
    end
    // PC+4 source
    drive(1'b1, 1'b1, 5'd1, 2'd2, 3'd0, 32'h55, 32'hABCD_0004);
    tick;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0);
    #1;
    n_cmp++;
    if (rf_wd !== 32'hABCD_0004) begin
      n_fail++;
      $display("FAIL pc4_write: wd=%h, required abcd0004", rf_wd);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s  [6] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]  offs [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd1};
    logic [31:0] exps [6] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080,
                              32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 5'd8, 2'd1, f3s[i], {30'h400, offs[i]}, 32'h0);
      tick;
      drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0);
      dmem_rdata = 32'h80FF_7F01;
      #1;
      n_cmp++;
      if ({rf_we, rf_wd} !== {1'b1, exps[i]}) begin
        n_fail++;
        $display("FAIL load_%0d: we=%b wd=%h, required 1 %h", i, rf_we, rf_wd, exps[i]);
      end
    end
  endtask

  task automatic test_x0;
    drive(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 32'h99, 32'h0);
    tick;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0);
    dec_ra1 = 5'd0;
    #1;
    n_cmp++;
    if ({rf_we, rf_fwd1, wb_valid} !== 3'b001) begin
      n_fail++;
      $display("FAIL x0_suppress: we=%b fwd1=%b valid=%b, required 0 0 1", rf_we, rf_fwd1, wb_valid);
    end
  endtask

  task automatic test_stall;
    logic [31:0] d0;
    d0 = $urandom;
    drive(1'b1, 1'b1, 5'd3, 2'd1, 3'd2, 32'h2000, 32'h0);
    tick;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0);
    dmem_rdata = d0; stall = 1'b1; dec_ra1 = 5'd3;
    #1;
    n_cmp++;
    if ({rf_we, rf_wd, rf_fwd1} !== {1'b1, d0, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_first: we=%b wd=%h fwd1=%b, required 1 %h 1", rf_we, rf_wd, rf_fwd1, d0);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      dmem_rdata = ~d0 ^ $urandom;
      #1;
      n_cmp++;
      if ({rf_we, rf_wd, rf_fwd1, wb_valid} !== {1'b0, d0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: we=%b wd=%h fwd1=%b valid=%b, required 0 %h 0 1",
                 i, rf_we, rf_wd, rf_fwd1, wb_valid, d0);
      end
    end
    stall = 1'b0;
    tick;
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: valid=%b, required 0", wb_valid);
    end
  endtask

  task automatic test_flush;
    drive(1'b1, 1'b1, 5'd9, 2'd0, 3'd0, 32'h77, 32'h0);
    flush = 1'b1;
    tick;
    n_cmp++;
    if ({wb_valid, rf_we} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_bubble: valid=%b we=%b, required 0 0", wb_valid, rf_we);
    end
    flush = 1'b0;
    drive(1'b1, 1'b1, 5'd10, 2'd0, 3'd0, 32'h55, 32'h0);
    tick;
    drive(1'b1, 1'b1, 5'd11, 2'd0, 3'd0, 32'h66, 32'h0);
    flush = 1'b1; stall = 1'b1;
    tick;
    n_cmp++;
    if ({wb_valid, rf_wa, rf_wd, rf_we} !== {1'b1, 5'd10, 32'h55, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_under_stall: valid=%b wa=%0d wd=%h we=%b, required 1 10 00000055 0",
               wb_valid, rf_wa, rf_wd, rf_we);
    end
    flush = 1'b0; stall = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0);
    tick;
  endtask

  // Randomized stream with back-to-back writes, stalls and flushes.
  task automatic test_back_to_back;
    logic        m_valid, m_we, m_written;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [2:0]  m_f3;
    logic [31:0] m_alu, m_pc, m_load, e_wd;
    logic        e_we;
    int          writes_seen, writes_exp;
    m_valid = 1'b0; m_we = 1'b0; m_written = 1'b0; m_rd = 5'd0; m_sel = 2'd0;
    m_f3 = 3'd0; m_alu = 32'h0; m_pc = 32'h0; m_load = 32'h0;
    writes_seen = 0; writes_exp = 0;
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), $urandom, $urandom);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      if (!stall) begin
        m_valid = mem_valid & ~flush; m_we = mem_reg_we; m_rd = mem_rd; m_sel = mem_wb_sel;
        m_f3 = mem_load_f3; m_alu = mem_alu_result; m_pc = mem_pc_plus4; m_written = 1'b0;
      end else begin
        m_written = 1'b1;
      end
      tick;
      dmem_rdata = $urandom;
      dec_ra1 = ($urandom_range(0, 1) != 0) ? m_rd : 5'($urandom_range(0, 31));
      dec_ra2 = ($urandom_range(0, 1) != 0) ? m_rd : 5'($urandom_range(0, 31));
      #1;
      if (!m_written) m_load = ref_load(dmem_rdata, m_alu[1:0], m_f3);
      e_we = m_valid && m_we && (m_rd != 5'd0) && !m_written;
      e_wd = (m_sel == 2'd1) ? m_load : (m_sel == 2'd2) ? m_pc : m_alu;
      writes_exp += int'(e_we);
      writes_seen += int'(rf_we === 1'b1);
      n_cmp++;
      if ({rf_we, rf_wa, rf_fwd1, rf_fwd2, wb_valid} !==
          {e_we, m_rd, e_we && (dec_ra1 == m_rd), e_we && (dec_ra2 == m_rd), m_valid}) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc %0d: we=%b wa=%0d fwd=%b%b valid=%b, required %b %0d %b%b %b",
                 c, rf_we, rf_wa, rf_fwd1, rf_fwd2, wb_valid, e_we, m_rd,
                 e_we && (dec_ra1 == m_rd), e_we && (dec_ra2 == m_rd), m_valid);
      end
      if (m_valid) begin
        n_cmp++;
        if (rf_wd !== e_wd) begin
          n_fail++;
          $display("FAIL rand_wd cyc %0d: wd=%h, required %h (sel=%0d f3=%0d)",
                   c, rf_wd, e_wd, m_sel, m_f3);
        end
      end
    end
    n_cmp++;
    if (writes_seen !== writes_exp) begin
      n_fail++;
      $display("FAIL rand_write_count: %0d writes, required %0d", writes_seen, writes_exp);
    end
    stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0);
    tick;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_loads;
    test_x0;
    test_stall;
    test_flush;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
